// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Groups the ID-stage instruction description and the hazard outputs that
// pass between the decode stage (master) and the hazard scoreboard (slave).
//
// Handshake: IDValid is the valid; !Stall is the ready. An instruction moves
// from ID to EXE (issues) on a rising edge where IDValid=1, Flush=0 and
// Stall=0. Anything else leaves the scoreboard state untouched apart from
// the normal per-cycle countdown. Flush squashes the ID instruction; it is
// never stalled, and Bubble tells the pipeline to put a NOP into ID/EXE.
//
// Signals
//   IDValid              valid instruction in ID
//   IDRs1/IDRs2          source register numbers
//   IDUsesRs1/IDUsesRs2  source is actually read
//   IDRd                 destination register number
//   IDWrites             instruction writes IDRd
//   IDIsLoad/IDIsMul     instruction class (mutually exclusive)
//   Flush                squash the ID instruction this cycle
//   Stall                hold PC and IF/ID (scoreboard output)
//   Bubble               insert NOP into ID/EXE (scoreboard output)
//   Busy                 some tracked result still pending (scoreboard output)
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if;
  logic       IDValid;
  logic [5:0] IDRs1;
  logic [5:0] IDRs2;
  logic       IDUsesRs1;
  logic       IDUsesRs2;
  logic [5:0] IDRd;
  logic       IDWrites;
  logic       IDIsLoad;
  logic       IDIsMul;
  logic       Flush;
  logic       Stall;
  logic       Bubble;
  logic       Busy;

  modport master (
    output IDValid, IDRs1, IDRs2, IDUsesRs1, IDUsesRs2,
    output IDRd, IDWrites, IDIsLoad, IDIsMul, Flush,
    input  Stall, Bubble, Busy
  );

  modport slave (
    input  IDValid, IDRs1, IDRs2, IDUsesRs1, IDUsesRs2,
    input  IDRd, IDWrites, IDIsLoad, IDIsMul, Flush,
    output Stall, Bubble, Busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Per-register pending-result counters for an in-order pipeline. A load
// result becomes forwardable one cycle after issue, a multiply result
// MUL_LAT cycles after issue; ALU results are always covered by forwarding.
// The single multiplier is not pipelined, so a second multiply waits until
// the occupancy counter has drained.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   sb   hazard_scoreboard_if.slave (ID instruction in, Stall/Bubble/Busy out)
//
// Parameter
//   MUL_LAT  multiply latency in cycles, legal 2..7 (fits the 3-bit counters)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_scoreboard_if.slave    sb
);

  localparam logic [2:0] MUL_LAT_C = 3'(MUL_LAT);

  logic [2:0] cnt [64];
  logic [2:0] mcnt;

  logic       src_hazard;
  logic       waw_hazard;
  logic       struct_hazard;
  logic       stall;
  logic       issue;
  logic       rd_set;
  logic [2:0] rd_lat;
  logic       busy;

  // Hazard detection is purely combinational from the registered counters
  // and the current ID fields, so Stall reacts in the same cycle.
  always_comb begin
    src_hazard    = (sb.IDUsesRs1 && (cnt[sb.IDRs1] != 3'd0)) ||
                    (sb.IDUsesRs2 && (cnt[sb.IDRs2] != 3'd0));
    waw_hazard    = sb.IDWrites && (sb.IDRd != 6'd0) && (cnt[sb.IDRd] != 3'd0);
    struct_hazard = sb.IDIsMul && (mcnt != 3'd0);
    stall         = sb.IDValid && !sb.Flush &&
                    (src_hazard || waw_hazard || struct_hazard);
    issue         = sb.IDValid && !sb.Flush && !stall;
    // ALU writers never mark their destination: forwarding covers them.
    rd_set        = issue && sb.IDWrites && (sb.IDRd != 6'd0) &&
                    (sb.IDIsLoad || sb.IDIsMul);
    rd_lat        = sb.IDIsLoad ? 3'd1 : MUL_LAT_C;
  end

  always_comb begin
    busy = (mcnt != 3'd0);
    for (int r = 1; r < 64; r++) begin
      busy = busy | (cnt[r] != 3'd0);
    end
  end

  assign sb.Stall  = stall;
  assign sb.Bubble = stall | (sb.IDValid & sb.Flush);
  assign sb.Busy   = busy;

  // Counters count down to zero every cycle; a fresh issue reloads the
  // counter and wins over the countdown. Register 0 is never tracked.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 64; r++) begin
        cnt[r] <= 3'd0;
      end
      mcnt <= 3'd0;
    end else begin
      cnt[0] <= 3'd0;
      for (int r = 1; r < 64; r++) begin
        if (rd_set && (sb.IDRd == 6'(r))) begin
          cnt[r] <= rd_lat;
        end else if (cnt[r] != 3'd0) begin
          cnt[r] <= cnt[r] - 3'd1;
        end
      end
      if (issue && sb.IDIsMul) begin
        mcnt <= MUL_LAT_C;
      end else if (mcnt != 3'd0) begin
        mcnt <= mcnt - 3'd1;
      end
    end
  end

endmodule
